// File: rtl/writeback_buffer.sv
// In-order writeback FIFO between the memory stage and the register-file/commit port.
// Two combinational lookups forward the youngest buffered result for a destination register.
module writeback_buffer #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 4,
   parameter int CTL_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [XLEN-1:0]            in_pc,
   input  logic [4:0]                 in_dst,
   input  logic                       in_wen,
   input  logic [XLEN-1:0]            in_wdata,
   input  logic [CTL_W-1:0]           in_ctl,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_pc,
   output logic [4:0]                 out_dst,
   output logic                       out_wen,
   output logic [XLEN-1:0]            out_wdata,
   output logic [CTL_W-1:0]           out_ctl,
   input  logic [4:0]                 fwd_addr1,
   input  logic [4:0]                 fwd_addr2,
   output logic                       fwd_hit1,
   output logic                       fwd_hit2,
   output logic [XLEN-1:0]            fwd_data1,
   output logic [XLEN-1:0]            fwd_data2,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [63:0]                commit_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [XLEN-1:0]  pc_mem    [DEPTH];
   logic [4:0]       dst_mem   [DEPTH];
   logic             wen_mem   [DEPTH];
   logic [XLEN-1:0]  wdata_mem [DEPTH];
   logic [CTL_W-1:0] ctl_mem   [DEPTH];

   logic [DEPTH-1:0] valid_reg;
   logic [AW-1:0]    head_reg;
   logic [AW-1:0]    tail_reg;
   logic [CW-1:0]    count_reg;
   logic [63:0]      commit_count_reg;

   logic push;
   logic pop;

   assign in_ready  = (count_reg != FULL_COUNT);
   assign out_valid = (count_reg != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_pc       = pc_mem[head_reg];
   assign out_dst      = dst_mem[head_reg];
   assign out_wen      = wen_mem[head_reg];
   assign out_wdata    = wdata_mem[head_reg];
   assign out_ctl      = ctl_mem[head_reg];
   assign occupancy    = count_reg;
   assign commit_count = commit_count_reg;

   // Payload storage carries no reset; only the valid bits give a slot meaning.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[tail_reg]    <= in_pc;
         dst_mem[tail_reg]   <= in_dst;
         wen_mem[tail_reg]   <= in_wen && (in_dst != 5'd0);
         wdata_mem[tail_reg] <= in_wdata;
         ctl_mem[tail_reg]   <= in_ctl;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg        <= '0;
         head_reg         <= '0;
         tail_reg         <= '0;
         count_reg        <= '0;
         commit_count_reg <= '0;
      end else begin
         if (push) begin
            valid_reg[tail_reg] <= 1'b1;
            tail_reg            <= tail_reg + AW'(1);
         end
         if (pop) begin
            valid_reg[head_reg] <= 1'b0;
            head_reg            <= head_reg + AW'(1);
            commit_count_reg    <= commit_count_reg + 64'd1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Walk oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      logic [AW-1:0] idx;
      idx       = '0;
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_reg + AW'(k);
         if (valid_reg[idx] && wen_mem[idx] && (fwd_addr1 != 5'd0) &&
             (dst_mem[idx] == fwd_addr1)) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = wdata_mem[idx];
         end
         if (valid_reg[idx] && wen_mem[idx] && (fwd_addr2 != 5'd0) &&
             (dst_mem[idx] == fwd_addr2)) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = wdata_mem[idx];
         end
      end
   end

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: a vector table for the main sequence plus
// hand-written reset-drop and same-cycle forwarding sequences.
module tb_writeback_buffer;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_pc;
   logic [4:0]  in_dst;
   logic        in_wen;
   logic [63:0] in_wdata;
   logic [15:0] in_ctl;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [4:0]  out_dst;
   logic        out_wen;
   logic [63:0] out_wdata;
   logic [15:0] out_ctl;
   logic [4:0]  fwd_addr1;
   logic [4:0]  fwd_addr2;
   logic        fwd_hit1;
   logic        fwd_hit2;
   logic [63:0] fwd_data1;
   logic [63:0] fwd_data2;
   logic [2:0]  occupancy;
   logic [63:0] commit_count;

   int checks   = 0;
   int failures = 0;

   writeback_buffer #(.XLEN(64), .DEPTH(4), .CTL_W(16)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_dst(in_dst),
      .in_wen(in_wen), .in_wdata(in_wdata), .in_ctl(in_ctl),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_dst(out_dst),
      .out_wen(out_wen), .out_wdata(out_wdata), .out_ctl(out_ctl),
      .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .occupancy(occupancy), .commit_count(commit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [63:0] pc;
      logic [4:0]  dst;
      logic        wen;
      logic [63:0] wd;
      logic        ordy;
      logic [4:0]  fa1;
      logic [4:0]  fa2;
      logic        e_ov;
      logic        e_ir;
      logic [2:0]  e_occ;
      logic [63:0] e_pc;
      logic [63:0] e_wd;
      logic        e_wen;
      logic        e_h1;
      logic [63:0] e_d1;
      logic        e_h2;
      logic [63:0] e_d2;
      logic [63:0] e_cc;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [15:0] ctl_of(input logic [63:0] pc);
      return pc[15:0] ^ 16'h5A5A;
   endfunction

   task automatic add(input logic iv, input logic [63:0] pc, input logic [4:0] dst,
                      input logic wen, input logic [63:0] wd, input logic ordy,
                      input logic [4:0] fa1, input logic [4:0] fa2,
                      input logic e_ov, input logic e_ir, input logic [2:0] e_occ,
                      input logic [63:0] e_pc, input logic [63:0] e_wd, input logic e_wen,
                      input logic e_h1, input logic [63:0] e_d1,
                      input logic e_h2, input logic [63:0] e_d2, input logic [63:0] e_cc);
      vec_t v;
      v.iv = iv; v.pc = pc; v.dst = dst; v.wen = wen; v.wd = wd; v.ordy = ordy;
      v.fa1 = fa1; v.fa2 = fa2; v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ;
      v.e_pc = e_pc; v.e_wd = e_wd; v.e_wen = e_wen; v.e_h1 = e_h1; v.e_d1 = e_d1;
      v.e_h2 = e_h2; v.e_d2 = e_d2; v.e_cc = e_cc;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [63:0] pc, input logic [4:0] dst,
                        input logic wen, input logic [63:0] wd, input logic ordy,
                        input logic [4:0] fa1, input logic [4:0] fa2);
      in_valid = iv; in_pc = pc; in_dst = dst; in_wen = wen; in_wdata = wd;
      in_ctl = ctl_of(pc); out_ready = ordy; fwd_addr1 = fa1; fwd_addr2 = fa2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Main sequence: fill to full, overflow attempt, in-order drain, x0 entry.
      add(1, 64'h80000000, 5, 1, 64'h1234, 0, 5, 0,  1, 1, 1, 64'h80000000, 64'h1234, 1, 1, 64'h1234, 0, 0, 0);
      add(1, 64'h80000004, 6, 1, 64'h2222, 0, 5, 6,  1, 1, 2, 64'h80000000, 64'h1234, 1, 1, 64'h1234, 1, 64'h2222, 0);
      add(1, 64'h80000008, 7, 1, 64'hA,    0, 7, 6,  1, 1, 3, 64'h80000000, 64'h1234, 1, 1, 64'hA,    1, 64'h2222, 0);
      add(1, 64'h8000000C, 7, 1, 64'hB,    0, 7, 5,  1, 0, 4, 64'h80000000, 64'h1234, 1, 1, 64'hB,    1, 64'h1234, 0);
      add(1, 64'h80000010, 9, 1, 64'h99,   0, 9, 7,  1, 0, 4, 64'h80000000, 64'h1234, 1, 0, 64'h0,    1, 64'hB,    0);
      add(0, 64'h0,        0, 0, 64'h0,    1, 5, 7,  1, 1, 3, 64'h80000004, 64'h2222, 1, 0, 64'h0,    1, 64'hB,    1);
      add(0, 64'h0,        0, 0, 64'h0,    1, 7, 6,  1, 1, 2, 64'h80000008, 64'hA,    1, 1, 64'hB,    0, 64'h0,    2);
      add(0, 64'h0,        0, 0, 64'h0,    1, 7, 0,  1, 1, 1, 64'h8000000C, 64'hB,    1, 1, 64'hB,    0, 64'h0,    3);
      add(0, 64'h0,        0, 0, 64'h0,    1, 7, 9,  0, 1, 0, 64'h0,        64'h0,    0, 0, 64'h0,    0, 64'h0,    4);
      add(1, 64'h80000020, 0, 1, 64'hFF,   0, 0, 0,  1, 1, 1, 64'h80000020, 64'hFF,   0, 0, 64'h0,    0, 64'h0,    4);
      add(0, 64'h0,        0, 0, 64'h0,    1, 0, 0,  0, 1, 0, 64'h0,        64'h0,    0, 0, 64'h0,    0, 64'h0,    5);
      // Streaming: first push into empty buffer, then 10 push+pop cycles across pointer wrap.
      add(1, 64'h100,      1, 1, 64'h10,   1, 1, 0,  1, 1, 1, 64'h100,      64'h10,   1, 1, 64'h10,   0, 64'h0,    5);
      for (int i = 0; i < 10; i++) begin
         logic [63:0] pc;
         logic [4:0]  dst;
         logic [63:0] wd;
         pc  = 64'h104 + 64'(4 * i);
         dst = 5'(1 + (i % 8));
         wd  = 64'h11 + 64'(i);
         add(1, pc, dst, 1, wd, 1, dst, 0, 1, 1, 1, pc, wd, 1, 1, wd, 0, 64'h0, 64'(6 + i));
      end
      // Two more pushes without popping leave 3 entries buffered for the reset test.
      add(1, 64'h200, 3, 1, 64'h33, 0, 3, 2,  1, 1, 2, 64'h128, 64'h1A, 1, 1, 64'h33, 1, 64'h1A, 15);
      add(1, 64'h204, 3, 1, 64'h44, 0, 3, 2,  1, 1, 3, 64'h128, 64'h1A, 1, 1, 64'h44, 1, 64'h1A, 15);

      drive(0, 0, 0, 0, 0, 0, 5, 0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_occupancy", 64'(occupancy), 64'd0);
      check("reset_commit_count", commit_count, 64'd0);
      check("reset_fwd_hit1", 64'(fwd_hit1), 64'd0);
      $display("txn reset: out_valid=%0b in_ready=%0b occ=%0d cc=%0d", out_valid, in_ready, occupancy, commit_count);
      tick();
      check("idle_out_valid", 64'(out_valid), 64'd0);

      foreach (vecs[n]) begin
         vec_t v;
         v = vecs[n];
         drive(v.iv, v.pc, v.dst, v.wen, v.wd, v.ordy, v.fa1, v.fa2);
         tick();
         $display("txn %0d: iv=%0b pc=%h dst=%0d ordy=%0b -> ov=%0b ir=%0b occ=%0d out_pc=%h h1=%0b d1=%h cc=%0d",
                  n, v.iv, v.pc, v.dst, v.ordy, out_valid, in_ready, occupancy, out_pc, fwd_hit1, fwd_data1, commit_count);
         check($sformatf("v%0d_out_valid", n), 64'(out_valid), 64'(v.e_ov));
         check($sformatf("v%0d_in_ready", n), 64'(in_ready), 64'(v.e_ir));
         check($sformatf("v%0d_occupancy", n), 64'(occupancy), 64'(v.e_occ));
         check($sformatf("v%0d_commit_count", n), commit_count, v.e_cc);
         check($sformatf("v%0d_fwd_hit1", n), 64'(fwd_hit1), 64'(v.e_h1));
         check($sformatf("v%0d_fwd_data1", n), fwd_data1, v.e_d1);
         check($sformatf("v%0d_fwd_hit2", n), 64'(fwd_hit2), 64'(v.e_h2));
         check($sformatf("v%0d_fwd_data2", n), fwd_data2, v.e_d2);
         if (v.e_ov) begin
            check($sformatf("v%0d_out_pc", n), out_pc, v.e_pc);
            check($sformatf("v%0d_out_wdata", n), out_wdata, v.e_wd);
            check($sformatf("v%0d_out_wen", n), 64'(out_wen), 64'(v.e_wen));
            check($sformatf("v%0d_out_ctl", n), 64'(out_ctl), 64'(ctl_of(v.e_pc)));
         end
      end

      // Reset with three entries buffered and out_ready high: nothing retires, all dropped.
      drive(0, 0, 0, 0, 0, 1, 3, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midreset_out_valid", 64'(out_valid), 64'd0);
      check("midreset_occupancy", 64'(occupancy), 64'd0);
      check("midreset_commit_count", commit_count, 64'd0);
      check("midreset_fwd_hit1", 64'(fwd_hit1), 64'd0);
      $display("txn midreset: out_valid=%0b occ=%0d cc=%0d", out_valid, occupancy, commit_count);
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("dropped_out_valid_%0d", i), 64'(out_valid), 64'd0);
         check($sformatf("dropped_commit_count_%0d", i), commit_count, 64'd0);
      end

      // Same-cycle forwarding: popping entry stays visible, pushing entry does not.
      drive(1, 64'h300, 12, 1, 64'hC1, 0, 12, 0);
      tick();
      check("fwdseq_occupancy", 64'(occupancy), 64'd1);
      drive(1, 64'h304, 12, 1, 64'hC2, 1, 12, 0);
      #1;
      check("fwdseq_pop_visible_hit", 64'(fwd_hit1), 64'd1);
      check("fwdseq_push_invisible_data", fwd_data1, 64'hC1);
      tick();
      $display("txn fwdseq: occ=%0d out_wdata=%h d1=%h cc=%0d", occupancy, out_wdata, fwd_data1, commit_count);
      check("fwdseq_after_occupancy", 64'(occupancy), 64'd1);
      check("fwdseq_after_out_wdata", out_wdata, 64'hC2);
      check("fwdseq_after_fwd_data", fwd_data1, 64'hC2);
      check("fwdseq_after_commit_count", commit_count, 64'd1);
      drive(0, 0, 0, 0, 0, 1, 12, 0);
      tick();
      check("fwdseq_drain_out_valid", 64'(out_valid), 64'd0);
      check("fwdseq_drain_fwd_hit", 64'(fwd_hit1), 64'd0);
      check("fwdseq_drain_commit_count", commit_count, 64'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
- Parametrised successor to the single-entry writeback stage.
- Accepts completed instructions from the memory stage through a valid/ready handshake and holds them in a DEPTH-entry in-order FIFO.
- Retires one entry per cycle to the register-file write port and commit/difftest logic through a second valid/ready handshake.
- Exposes two combinational forwarding lookups over the buffered entries, so decode/execute can bypass results not yet written to the register file.

Parameters:
- XLEN, 64, data and PC width.
- DEPTH, 4, buffer entries; power of two, at least 2.
- CTL_W, 16, width of the opaque control bundle carried through unchanged.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  buffer can accept.
- in_pc  in  XLEN  instruction PC.
- in_dst  in  5  destination register.
- in_wen  in  1  register write enable.
- in_wdata  in  XLEN  writeback data.
- in_ctl  in  CTL_W  control bundle.
- out_valid  out  1  head entry available.
- out_ready  in  1  register file / commit accepts the head.
- out_pc  out  XLEN  head PC.
- out_dst  out  5  head destination register.
- out_wen  out  1  head write enable.
- out_wdata  out  XLEN  head data.
- out_ctl  out  CTL_W  head control bundle.
- fwd_addr1, fwd_addr2  in  5 each  forwarding lookup addresses.
- fwd_hit1, fwd_hit2  out  1 each  lookup matched a buffered entry.
- fwd_data1, fwd_data2  out  XLEN each  forwarded data.
- occupancy  out  $clog2(DEPTH)+1  current entry count.
- commit_count  out  64  retired-instruction counter.

Behaviour:
- Reset (synchronous, high at a clk edge):
  - head pointer, tail pointer, count and commit_count go to 0; all entry valid bits clear.
  - out_valid=0, in_ready=1, fwd_hit*=0, occupancy=0.
  - Asserting reset mid-operation discards all buffered entries; nothing retires in that cycle.
- Push: in_valid && in_ready at a clk edge writes the entry at the tail, and the tail advances modulo DEPTH.
  - Stored wen is forced to 0 when in_dst==0, so x0 is never written and never forwarded.
- Pop: out_valid && out_ready at a clk edge invalidates the head, advances the head modulo DEPTH, and increments commit_count (64-bit, wraps).
  - Entries with wen=0 still retire and still count.
- Ready and valid:
  - in_ready = (count != DEPTH). It does not depend on out_ready, so there is no full-buffer pass-through.
  - out_valid = (count != 0).
  - out_* are driven combinationally from the head entry registers.
- Latency: an entry pushed at edge t is visible on out_* from just after t. Minimum in-to-out is 1 cycle; there is no combinational in->out path.
- Simultaneous push and pop: both take effect and count is unchanged. When empty, only the push occurs (out_valid was 0).
- Full: in_ready=0 and in_valid is ignored; the upstream stage must hold its payload.
- Empty: out_valid=0 and out_* values are don't-care.
- Pointer wrap: pointers are $clog2(DEPTH) bits; count disambiguates full from empty.
- Forwarding (combinational, per port):
  - Searches valid entries with wen=1 and dst==fwd_addr.
  - The youngest match, closest to tail, wins, and its data drives fwd_data.
  - No match, or fwd_addr==0: hit=0 and data=0.
  - An entry being popped this cycle is still visible.
  - An entry being pushed this cycle is not visible; the caller bypasses from the memory stage itself.
- occupancy = count.
- Payloads are held unchanged while an entry is valid; payloads of invalid slots are don't-care.

Test Plan:
- Reset, then idle → out_valid=0, in_ready=1, occupancy=0, commit_count=0, fwd_hit1=0 for any address.
- Push pc=0x80000000,dst=5,wdata=0x1234,wen=1 with out_ready=0 → next cycle out_valid=1, out_pc=0x80000000, out_wdata=0x1234; fwd_addr1=5 gives hit=1, data=0x1234.
- Push 4 entries with out_ready=0 → occupancy=4, in_ready=0; a 5th in_valid is ignored; raise out_ready → entries retire in order, one per cycle, and commit_count reaches 4.
- Entries dst=7/0xA then dst=7/0xB buffered → fwd_data=0xB (youngest); pop the first → still 0xB; pop both → hit=0.
- Push dst=0,wen=1,wdata=0xFF → out_wen=0; fwd_addr=0 gives hit=0; the entry still retires and commit_count increments.
- Run streaming push+pop every cycle for 10 cycles across pointer wrap, then assert reset with 3 entries buffered → occupancy stays at 1 during streaming; after reset, out_valid=0, occupancy=0, commit_count=0, and the dropped entries never appear on out_*.
